// File: rtl/dp_sram_pipe.sv
// dp_sram_pipe: simple dual-port SRAM (one write port, one read port) with
// byte-lane write strobes and a 1- or 2-stage registered read pipeline.
// Optional feature macro: SRAM_WR_BYPASS_EN
//   defined   -> same-address read-during-write returns write-first data
//   undefined -> read-first (old word); no bypass logic is built.
// The memory array itself is never reset; only the read pipeline is.
module dp_sram_pipe #(
    parameter int AW     = 8,
    parameter int DW     = 32,
    parameter int RD_LAT = 1    // 1 or 2; any value other than 2 builds the 1-cycle path
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wren_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [DW/8-1:0] wstrb_i,
    input  logic [DW-1:0]   wdata_i,
    input  logic            rden_i,
    input  logic [AW-1:0]   raddr_i,
    output logic            rvalid_o,
    output logic [DW-1:0]   rdata_o
);

    localparam int NB    = DW / 8;
    localparam int DEPTH = 2 ** AW;

    // Old contents of ram[raddr_i], assembled from the per-lane arrays.
    logic [DW-1:0] rd_old;
    // Word captured into the first read stage (after optional bypass merge).
    logic [DW-1:0] rd_word;

    // One 8-bit array per byte lane so each lane has its own write enable
    // and no two processes ever drive the same storage.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : gen_lane
            logic [7:0] lane_mem [DEPTH];

            // Lane write; suppressed while reset is held.
            always_ff @(posedge clk) begin
                if (rst_n && wren_i && wstrb_i[gi]) begin
                    lane_mem[waddr_i] <= wdata_i[gi*8 +: 8];
                end
            end

            assign rd_old[gi*8 +: 8] = lane_mem[raddr_i];
        end
    endgenerate

`ifdef SRAM_WR_BYPASS_EN
    // Write-first: on a same-address collision the strobed lanes come from
    // the incoming write data, the remaining lanes from the stored word.
    logic byp_hit;
    assign byp_hit = wren_i && (waddr_i == raddr_i);

    generate
        for (gi = 0; gi < NB; gi++) begin : gen_byp
            assign rd_word[gi*8 +: 8] = (byp_hit && wstrb_i[gi]) ? wdata_i[gi*8 +: 8]
                                                                 : rd_old[gi*8 +: 8];
        end
    endgenerate
`else
    // Read-first: a colliding read simply sees the word before the write.
    assign rd_word = rd_old;
`endif

    logic          rd1_valid_reg;
    logic [DW-1:0] rd1_data_reg;

    // First read stage: registered array read; data only moves on a read
    // so the output holds its last value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_valid_reg <= 1'b0;
            rd1_data_reg  <= '0;
        end else begin
            rd1_valid_reg <= rden_i;
            if (rden_i) begin
                rd1_data_reg <= rd_word;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : gen_lat2
            logic          rd2_valid_reg;
            logic [DW-1:0] rd2_data_reg;

            // Second read stage: extra output register, fully pipelined.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd2_valid_reg <= 1'b0;
                    rd2_data_reg  <= '0;
                end else begin
                    rd2_valid_reg <= rd1_valid_reg;
                    if (rd1_valid_reg) begin
                        rd2_data_reg <= rd1_data_reg;
                    end
                end
            end

            assign rvalid_o = rd2_valid_reg;
            assign rdata_o  = rd2_data_reg;
        end else begin : gen_lat1
            assign rvalid_o = rd1_valid_reg;
            assign rdata_o  = rd1_data_reg;
        end
    endgenerate

endmodule

// File: tb/tb_dp_sram_pipe.sv
// tb_dp_sram_pipe: drives one RD_LAT=1 and one RD_LAT=2 instance with the
// same directed stimulus; a negedge monitor checks each read against a
// scoreboard queue holding hand-computed data and the expected cycle.
module tb_dp_sram_pipe;

`ifdef SRAM_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wren;
    logic [7:0]  waddr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        rden;
    logic [7:0]  raddr;
    logic        rv1, rv2;
    logic [31:0] rd1, rd2;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb [2][$];
    logic [31:0] last_exp [2];

    dp_sram_pipe #(.AW(8), .DW(32), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .wren_i(wren), .waddr_i(waddr), .wstrb_i(wstrb), .wdata_i(wdata),
        .rden_i(rden), .raddr_i(raddr),
        .rvalid_o(rv1), .rdata_o(rd1)
    );

    dp_sram_pipe #(.AW(8), .DW(32), .RD_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .wren_i(wren), .waddr_i(waddr), .wstrb_i(wstrb), .wdata_i(wdata),
        .rden_i(rden), .raddr_i(raddr),
        .rvalid_o(rv2), .rdata_o(rd2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %08h required %08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard monitor for one port.
    task automatic mon_port(input int p, input logic v, input logic [31:0] d);
        exp_t e;
        if (!rst_n) begin
            chk($sformatf("rst_rvalid_p%0d", p), {31'b0, v}, 32'd0);
            chk($sformatf("rst_rdata_p%0d", p), d, 32'd0);
            last_exp[p] = 32'd0;
        end else if (v) begin
            if (sb[p].size() == 0) begin
                chk($sformatf("spurious_rvalid_p%0d", p), {31'b0, v}, 32'd0);
            end else begin
                e = sb[p].pop_front();
                chk($sformatf("rdata_p%0d", p), d, e.data);
                chk($sformatf("latency_p%0d", p), 32'(cyc), 32'(e.due));
                last_exp[p] = e.data;
                $display("read p%0d data=%08h cycle=%0d", p, d, cyc);
            end
        end else begin
            if (sb[p].size() > 0 && sb[p][0].due <= cyc) begin
                e = sb[p].pop_front();
                chk($sformatf("missing_rvalid_p%0d", p), {31'b0, v}, 32'd1);
            end
            chk($sformatf("hold_rdata_p%0d", p), d, last_exp[p]);
        end
    endtask

    always @(negedge clk) begin
        mon_port(0, rv1, rd1);
        mon_port(1, rv2, rd2);
    end

    task automatic drive(input logic we, input logic [7:0] wa, input logic [3:0] ws,
                         input logic [31:0] wd, input logic re, input logic [7:0] ra,
                         input logic push, input logic [31:0] exp_data);
        exp_t e;
        @(posedge clk);
        #1;
        wren  = we;
        waddr = wa;
        wstrb = ws;
        wdata = wd;
        rden  = re;
        raddr = ra;
        if (re && push) begin
            e.data = exp_data;
            e.due  = cyc + 1;
            sb[0].push_back(e);
            e.due  = cyc + 2;
            sb[1].push_back(e);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [3:0] s, input logic [31:0] d);
        drive(1'b1, a, s, d, 1'b0, 8'h00, 1'b0, 32'h0);
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp_data);
        drive(1'b0, 8'h00, 4'h0, 32'h0, 1'b1, a, 1'b1, exp_data);
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 8'h00, 1'b0, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        wren  = 1'b0;
        waddr = '0;
        wstrb = '0;
        wdata = '0;
        rden  = 1'b0;
        raddr = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Full-word write then read on the next cycle.
        wr(8'h10, 4'hF, 32'hDEADBEEF);
        rd(8'h10, 32'hDEADBEEF);

        // Partial strobe merge, then all-zero strobe leaves the word alone.
        wr(8'h20, 4'hF, 32'h11223344);
        wr(8'h20, 4'h5, 32'hAABBCCDD);
        rd(8'h20, 32'h11BB33DD);
        wr(8'h20, 4'h0, 32'hFFFFFFFF);
        rd(8'h20, 32'h11BB33DD);

        // Back-to-back reads including the top address and wrap to zero.
        wr(8'h00, 4'hF, 32'h0000A5A5);
        wr(8'hFF, 4'hF, 32'hFFFF0000);
        wr(8'h01, 4'hF, 32'h01010101);
        rd(8'h00, 32'h0000A5A5);
        rd(8'hFF, 32'hFFFF0000);
        rd(8'h01, 32'h01010101);
        rd(8'h00, 32'h0000A5A5);
        rd(8'hFF, 32'hFFFF0000);
        rd(8'h00, 32'h0000A5A5);

        // Same-edge read/write collisions, full and partial strobe.
        wr(8'h30, 4'hF, 32'h00000000);
        drive(1'b1, 8'h30, 4'hF, 32'h12345678, 1'b1, 8'h30, 1'b1,
              BYP ? 32'h12345678 : 32'h00000000);
        rd(8'h30, 32'h12345678);
        drive(1'b1, 8'h30, 4'h3, 32'hFFFFFFFF, 1'b1, 8'h30, 1'b1,
              BYP ? 32'h1234FFFF : 32'h12345678);
        // Write to a different address while reading: no interaction.
        drive(1'b1, 8'h31, 4'hF, 32'hAAAAAAAA, 1'b1, 8'h30, 1'b1, 32'h1234FFFF);
        rd(8'h31, 32'hAAAAAAAA);

        // Read then idle: rvalid drops, rdata holds.
        wr(8'h40, 4'hF, 32'hCAFEF00D);
        rd(8'h40, 32'hCAFEF00D);
        repeat (5) idle();
        chk("idle_rvalid_lat1", {31'b0, rv1}, 32'd0);
        chk("idle_rdata_lat1", rd1, 32'hCAFEF00D);
        chk("idle_rvalid_lat2", {31'b0, rv2}, 32'd0);
        chk("idle_rdata_lat2", rd2, 32'hCAFEF00D);

        // Reset mid-read: in-flight read discarded, writes during reset ignored.
        wr(8'h50, 4'hF, 32'h55667788);
        drive(1'b0, 8'h00, 4'h0, 32'h0, 1'b1, 8'h50, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        rden  = 1'b0;
        wren  = 1'b1;
        waddr = 8'h50;
        wstrb = 4'hF;
        wdata = 32'hDEADDEAD;
        #1;
        chk("rst_imm_rvalid_lat1", {31'b0, rv1}, 32'd0);
        chk("rst_imm_rdata_lat1", rd1, 32'd0);
        chk("rst_imm_rvalid_lat2", {31'b0, rv2}, 32'd0);
        chk("rst_imm_rdata_lat2", rd2, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        wren  = 1'b0;
        rst_n = 1'b1;
        repeat (4) idle();
        rd(8'h50, 32'h55667788);
        idle();

        // Let outstanding reads complete, bounded.
        for (int i = 0; i < 20 && (sb[0].size() + sb[1].size()) > 0; i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        chk("drain_pending", 32'(sb[0].size() + sb[1].size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dp_sram_pipe.md
DP_SRAM_PIPE -- requirements
Module: dp_sram_pipe

Interface
REQ-001 SHALL have parameter AW, default 8, address width; depth 2**AW words.
REQ-002 SHALL have parameter DW, default 32, data width; multiple of 8.
REQ-003 SHALL have parameter RD_LAT, default 1, read latency in cycles; legal values 1 or 2.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port wren_i  input  1  write request.
REQ-007 SHALL have port waddr_i  input  AW  write address.
REQ-008 SHALL have port wstrb_i  input  DW/8  byte-lane write enables; bit k covers wdata_i[8k+7:8k].
REQ-009 SHALL have port wdata_i  input  DW  write data.
REQ-010 SHALL have port rden_i  input  1  read request.
REQ-011 SHALL have port raddr_i  input  AW  read address.
REQ-012 SHALL have port rvalid_o  output  1  rdata_o carries the result of a read this cycle.
REQ-013 SHALL have port rdata_o  output  DW  read data.

Function
REQ-014 SHALL, on a posedge with wren_i=1, write wdata_i byte lanes whose wstrb_i bit is 1 to ram[waddr_i]; lanes with strobe 0 are unchanged.
REQ-015 SHALL leave memory unchanged when wren_i=1 and wstrb_i is all zero.
REQ-016 SHALL sample raddr_i when rden_i=1 at edge N and present data with rvalid_o=1 after edge N+RD_LAT-1, i.e. visible in cycle N+RD_LAT.
REQ-017 SHALL, with RD_LAT=2, register the array output once more; one read accepted per cycle, fully pipelined, no stalls.
REQ-018 SHALL drive rvalid_o=0 in every cycle without a completing read.
REQ-019 SHALL hold rdata_o at its last read value when rvalid_o=0; rdata_o changes only on read completion or reset.
REQ-020 SHALL resolve read-during-write to the same address at the same edge per the SRAM_WR_BYPASS_EN setting (REQ-025/026); different addresses never interact.
REQ-021 SHALL treat back-to-back reads of any addresses, including address wrap from 2**AW-1 to 0, identically; no address checking.

Reset
REQ-022 SHALL, while rst_n=0, force rvalid_o=0, rdata_o=0 and clear all read-pipeline valid and data stages asynchronously.
REQ-023 SHALL discard reads in flight when reset asserts mid-operation; no rvalid_o pulse for them after release.
REQ-024 SHALL NOT reset the memory array; contents undefined until written; writes are ignored while rst_n=0.

Configuration
REQ-025 SHALL, with macro SRAM_WR_BYPASS_EN defined, return write-first data on same-address collision: strobed lanes from wdata_i, other lanes from the old word.
REQ-026 SHALL, with SRAM_WR_BYPASS_EN undefined, return read-first data (old word) on collision; no bypass comparator or mux is built.

Verification
REQ-027 SHALL cover: RD_LAT=1, write 0xDEADBEEF strobe 0xF to addr 0x10, next cycle read 0x10 -> rvalid_o=1 and rdata_o=0xDEADBEEF one cycle after the read edge.
REQ-028 SHALL cover: ram[0x20]=0x11223344, write 0xAABBCCDD strobe 0x5 to 0x20, read 0x20 -> 0x11BB33DD.
REQ-029 SHALL cover: RD_LAT=2, reads on 4 consecutive cycles to 0x00,0xFF,0x01,0x00 -> 4 consecutive rvalid_o pulses starting two cycles after first read, data in order.
REQ-030 SHALL cover: ram[0x30]=0x0, same edge write 0x12345678 strobe 0xF and read 0x30 -> rdata_o=0x12345678 with SRAM_WR_BYPASS_EN, 0x00000000 without.
REQ-031 SHALL cover: RD_LAT=2, read issued, rst_n pulled low before completion -> rvalid_o=0 and rdata_o=0 immediately, no rvalid_o after release.
REQ-032 SHALL cover: read 0x40 returns 0xCAFEF00D, then 5 idle cycles -> rvalid_o=0 and rdata_o holds 0xCAFEF00D.
